// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster-order pixel stream.
// Two line buffers feed a sliding window; products and an adder tree are pipelined behind it.
module conv3x3_stream #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIXEL_WIDTH  = 8,
    parameter int KERNEL_WIDTH = 8,
    parameter int OUT_WIDTH    = PIXEL_WIDTH + KERNEL_WIDTH + 4,
    localparam int X_W         = $clog2(IMG_WIDTH),
    localparam int Y_W         = $clog2(IMG_HEIGHT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [KERNEL_WIDTH-1:0] kernel [0:2][0:2],
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic        [PIXEL_WIDTH-1:0]  in_pixel,
    output logic                           out_valid,
    output logic signed [OUT_WIDTH-1:0]    out_data,
    output logic        [X_W-1:0]          out_x,
    output logic        [Y_W-1:0]          out_y
);

    localparam int PROD_W = PIXEL_WIDTH + KERNEL_WIDTH + 1;

    logic [X_W-1:0] col_reg, col_next, cur_col;
    logic [Y_W-1:0] row_reg, row_next, cur_row;
    logic           complete;

    // Start-of-frame overrides the counters for the pixel that carries it.
    always_comb begin
        cur_col  = in_sof ? '0 : col_reg;
        cur_row  = in_sof ? '0 : row_reg;
        col_next = col_reg;
        row_next = row_reg;
        if (in_valid) begin
            if (cur_col == X_W'(IMG_WIDTH - 1)) begin
                col_next = '0;
                row_next = (cur_row == Y_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + Y_W'(1);
            end else begin
                col_next = cur_col + X_W'(1);
                row_next = cur_row;
            end
        end
    end

    assign complete = (cur_row >= Y_W'(2)) && (cur_col >= X_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    logic [PIXEL_WIDTH-1:0] lb0 [0:IMG_WIDTH-1];
    logic [PIXEL_WIDTH-1:0] lb1 [0:IMG_WIDTH-1];
    logic [PIXEL_WIDTH-1:0] win_reg [0:2][0:2];
    logic [PIXEL_WIDTH-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    // Storage only; the row>=2 gate keeps stale contents from ever reaching the output.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[cur_col] <= lb0_rd;
            lb0[cur_col] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                win_reg[r][0] <= win_reg[r][1];
                win_reg[r][1] <= win_reg[r][2];
            end
            win_reg[0][2] <= lb1_rd;
            win_reg[1][2] <= lb0_rd;
            win_reg[2][2] <= in_pixel;
        end
    end

    // Nine products; pixels are zero-extended so they stay non-negative in signed math.
    for (genvar gi = 0; gi < 9; gi++) begin : g_mul
        localparam int R = gi / 3;
        localparam int C = gi % 3;
        logic signed [PROD_W-1:0] p_reg;
        always_ff @(posedge clk) begin
            p_reg <= PROD_W'($signed({1'b0, win_reg[R][C]})) * PROD_W'(kernel[R][C]);
        end
    end

    // Row partial sums split the nine-term addition across two register stages.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic signed [OUT_WIDTH-1:0] sum_reg;
        always_ff @(posedge clk) begin
            sum_reg <= OUT_WIDTH'(g_mul[3*gi].p_reg)
                     + OUT_WIDTH'(g_mul[3*gi+1].p_reg)
                     + OUT_WIDTH'(g_mul[3*gi+2].p_reg);
        end
    end

    logic           s1_valid, s2_valid, s3_valid;
    logic [X_W-1:0] s1_x, s2_x, s3_x;
    logic [Y_W-1:0] s1_y, s2_y, s3_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_x      <= '0;
            s2_x      <= '0;
            s3_x      <= '0;
            s1_y      <= '0;
            s2_y      <= '0;
            s3_y      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            s1_valid <= in_valid && complete;
            if (in_valid && complete) begin
                s1_x <= cur_col - X_W'(1);
                s1_y <= cur_row - Y_W'(1);
            end
            s2_valid  <= s1_valid;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s3_valid  <= s2_valid;
            s3_x      <= s2_x;
            s3_y      <= s2_y;
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_data <= g_row[0].sum_reg + g_row[1].sum_reg + g_row[2].sum_reg;
                out_x    <= s3_x;
                out_y    <= s3_y;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomized bench for conv3x3_stream: a frame-image model predicts every result and its
// due cycle; a negedge process compares outputs each cycle, plus literal Sobel/saturation-free checks.
module tb_conv3x3_stream;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int KW = 8;
    localparam int OW = PW + KW + 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [KW-1:0] kernel [0:2][0:2];
    logic                 in_valid = 1'b0;
    logic                 in_sof   = 1'b0;
    logic        [PW-1:0] in_pixel = '0;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic        [2:0]    out_x;
    logic        [1:0]    out_y;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kernel   (kernel),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_x    (out_x),
        .out_y    (out_y)
    );

    typedef struct {
        int due;
        int d;
        int x;
        int y;
    } exp_t;

    exp_t q[$];
    int   img [0:H-1][0:W-1];
    int   mx = 0, my = 0, edge_cnt = 0;
    int   tests = 0, fails = 0, n_out = 0;
    bit   chk_en = 1'b0, lit_en = 1'b0;
    int   lit_data = 0;
    int   last_d = 0, last_x = 0, last_y = 0;

    function automatic void chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    // Plain definition of the 3x3 dot product over the most recent frame image.
    function automatic int conv_at(int x, int y);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(kernel[i][j]) * img[y-2+i][x-2+j];
        return s;
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            mx = 0;
            my = 0;
        end else if (in_valid) begin
            if (in_sof) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = int'(in_pixel);
            if (mx >= 2 && my >= 2) q.push_back('{edge_cnt + 3, conv_at(mx, my), mx - 1, my - 1});
            mx++;
            if (mx == W) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit   want;
            exp_t e;
            if (rst) begin
                q.delete();
                last_d = 0;
                last_x = 0;
                last_y = 0;
            end
            want = (q.size() > 0) && (q[0].due == edge_cnt);
            chk("out_valid", 32'(out_valid), 32'(want));
            if (want) begin
                e = q.pop_front();
                last_d = e.d;
                last_x = e.x;
                last_y = e.y;
                if (out_valid) n_out++;
                if (lit_en) chk("literal_data", 32'(out_data), lit_data);
            end
            chk("out_data", 32'(out_data), last_d);
            chk("out_x", 32'(out_x), last_x);
            chk("out_y", 32'(out_y), last_y);
        end
    end

    task automatic drive(bit v, bit sof, logic [PW-1:0] pix);
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    function automatic logic [PW-1:0] pix_of(int mode, int y);
        if (mode == 0) return 8'(y * 10);
        if (mode == 1) return 8'd255;
        return 8'($urandom_range(0, 255));
    endfunction

    // gap: 0 continuous, 1 alternate valid/idle, 2 random idle cycles
    task automatic send_pixels(int mode, int gap, bit sof, int n);
        for (int k = 0; k < n; k++) begin
            if (gap == 1 && k != 0) drive(1'b0, 1'b0, 8'($urandom));
            else if (gap == 2 && $urandom_range(0, 2) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            drive(1'b1, sof && (k == 0), pix_of(mode, (k / W) % H));
        end
    endtask

    task automatic set_kernel_const(int v);
        for (int k = 0; k < 9; k++) kernel[k/3][k%3] = 8'(v);
    endtask

    task automatic set_sobel();
        int sob [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        for (int k = 0; k < 9; k++) kernel[k/3][k%3] = 8'(sob[k]);
    endtask

    task automatic set_random_kernel();
        for (int k = 0; k < 9; k++) kernel[k/3][k%3] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_phase(string name, int mode, int gap, bit sof, int frames, int expected);
        int base = n_out;
        for (int f = 0; f < frames; f++) send_pixels(mode, gap, sof, W * H);
        idle(8);
        chk(name, n_out - base, expected);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        set_sobel();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sobel-Y over rows of 0,10,20,30: every window gives 4*20 = 80
        lit_en = 1'b1;
        lit_data = 80;
        run_phase("sobel_count", 0, 0, 1'b0, 1, 6);

        set_kernel_const(127);
        lit_data = 291465;
        run_phase("max_pos_count", 1, 0, 1'b1, 1, 6);

        set_kernel_const(-128);
        lit_data = -293760;
        run_phase("max_neg_count", 1, 0, 1'b1, 1, 6);

        set_sobel();
        lit_data = 80;
        run_phase("toggle_count", 0, 1, 1'b1, 1, 6);
        lit_en = 1'b0;

        set_random_kernel();
        run_phase("two_frames_count", 2, 0, 1'b1, 2, 12);

        set_random_kernel();
        run_phase("random_gap_count", 2, 2, 1'b1, 3, 18);

        // sof arrives on what would have been pixel (3,2): one in-flight result then a fresh frame
        set_random_kernel();
        base = n_out;
        send_pixels(2, 0, 1'b1, 2 * W + 3);
        send_pixels(2, 0, 1'b1, W * H);
        idle(8);
        chk("mid_sof_count", n_out - base, 7);

        // reset with results for (2,2),(3,2),(4,2) still in the pipeline
        set_sobel();
        lit_en = 1'b1;
        base = n_out;
        send_pixels(0, 0, 1'b1, 3 * W);
        rst = 1'b1;
        in_valid = 1'b0;
        #2;
        chk("rst_async_valid", 32'(out_valid), 0);
        chk("rst_async_data", 32'(out_data), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("rst_drop_count", n_out - base, 0);
        run_phase("after_rst_count", 0, 0, 1'b0, 1, 6);
        lit_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
